// File: rtl/useq_pkg.sv
// useq_pkg: shared state encoding, microcode entry addresses and widths for micro_sequencer.
package useq_pkg;
    localparam int UPC_W = 6;
    typedef enum logic [2:0] {IDLE, DISPATCH, WAIT_MEM, WAIT_MUL, RETIRE} useq_state_t;
    localparam logic [UPC_W-1:0] ADDR_LOAD    = 6'd11;
    localparam logic [UPC_W-1:0] ADDR_STORE   = 6'd12;
    localparam logic [UPC_W-1:0] ADDR_MUL_LO  = 6'd27;
    localparam logic [UPC_W-1:0] ADDR_MUL_HI  = 6'd29;
    localparam logic [UPC_W-1:0] ADDR_MRET    = 6'd36;
    localparam logic [UPC_W-1:0] ADDR_ILLEGAL = 6'd63;
endpackage

// File: rtl/useq_wait_timer.sv
// useq_wait_timer: memory wait counter; expired when LIMIT-1 stalled cycles have been counted.
module useq_wait_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [7:0] cnt;
    always_ff @(posedge clk)
        if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 8'd1;
    assign expired = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: dispatches mapped microcode entries, waits on memory/multiplier, retires.
// Define USEQ_MUL_EN to route addresses 27..29 through the multiplier wait; otherwise they are illegal.
module micro_sequencer
    import useq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [UPC_W-1:0] mapped_address,
    output logic             dec_ready,
    input  logic             mem_ready,
    input  logic             mul_done,
    output logic [UPC_W-1:0] upc,
    output logic             issue,
    output logic             mem_req,
    output logic             mul_start,
    output logic             retire,
    output logic             illegal,
    output logic             trap_return,
    output logic             timeout
);
    useq_state_t state, next;
    logic expired, is_mem, in_mul, mul_path, bad;
    assign is_mem = upc == ADDR_LOAD || upc == ADDR_STORE;
    assign in_mul = upc >= ADDR_MUL_LO && upc <= ADDR_MUL_HI;
`ifdef USEQ_MUL_EN
    assign mul_path = in_mul;
    assign bad      = upc > ADDR_MRET;
`else
    logic unused_mul_done;
    assign unused_mul_done = mul_done;
    assign mul_path = 1'b0;
    assign bad      = upc > ADDR_MRET || in_mul;
`endif
    useq_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .clear  (reset || state != WAIT_MEM),
        .enable (state == WAIT_MEM && !mem_ready),
        .expired(expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            upc   <= '0;
        end else begin
            state <= next;
            if (state == IDLE && dec_valid) upc <= mapped_address;
        end
    end
    always_comb begin
        next = IDLE;
        case (state)
            IDLE:     next = dec_valid ? DISPATCH : IDLE;
            DISPATCH: next = bad ? IDLE : is_mem ? WAIT_MEM : mul_path ? WAIT_MUL : RETIRE;
            WAIT_MEM: next = mem_ready ? RETIRE : expired ? IDLE : WAIT_MEM;
`ifdef USEQ_MUL_EN
            WAIT_MUL: next = mul_done ? RETIRE : WAIT_MUL;
`endif
            RETIRE:   next = IDLE;
            default:  next = IDLE;
        endcase
    end
    // Outputs are gated by reset so nothing is asserted while it is held.
    always_comb begin
        dec_ready   = !reset && state == IDLE;
        issue       = !reset && state == DISPATCH;
        illegal     = issue && bad;
        mul_start   = issue && mul_path;
        mem_req     = !reset && state == WAIT_MEM;
        timeout     = mem_req && !mem_ready && expired;
        retire      = !reset && state == RETIRE;
        trap_return = retire && upc == ADDR_MRET;
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed and randomized checks of micro_sequencer against cycle-level expectations.
module tb_micro_sequencer;
    localparam logic [7:0] DR = 8'h80, IS = 8'h40, MQ = 8'h20, MS = 8'h10;
    localparam logic [7:0] RT = 8'h08, IL = 8'h04, TR = 8'h02, TO = 8'h01;
`ifdef USEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1, dec_valid = 1'b0, mem_ready = 1'b0, mul_done = 1'b0;
    logic [5:0] mapped_address = '0;
    logic [5:0] upc, upc4;
    logic dec_ready, issue, mem_req, mul_start, retire, illegal, trap_return, timeout;
    logic dec_ready4, issue4, mem_req4, mul_start4, retire4, illegal4, trap_return4, timeout4;
    logic [7:0] obs, obs4;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    micro_sequencer dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .mapped_address(mapped_address),
        .dec_ready(dec_ready), .mem_ready(mem_ready), .mul_done(mul_done), .upc(upc),
        .issue(issue), .mem_req(mem_req), .mul_start(mul_start), .retire(retire),
        .illegal(illegal), .trap_return(trap_return), .timeout(timeout)
    );
    micro_sequencer #(.MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .mapped_address(mapped_address),
        .dec_ready(dec_ready4), .mem_ready(mem_ready), .mul_done(mul_done), .upc(upc4),
        .issue(issue4), .mem_req(mem_req4), .mul_start(mul_start4), .retire(retire4),
        .illegal(illegal4), .trap_return(trap_return4), .timeout(timeout4)
    );
    assign obs  = {dec_ready, issue, mem_req, mul_start, retire, illegal, trap_return, timeout};
    assign obs4 = {dec_ready4, issue4, mem_req4, mul_start4, retire4, illegal4, trap_return4, timeout4};

    // One clock cycle: inputs change just after the edge, outputs are sampled mid-cycle.
    task automatic cyc(input logic r, input logic v, input logic [5:0] a, input logic mr, input logic md);
        @(posedge clk);
        #1;
        reset = r; dec_valid = v; mapped_address = a; mem_ready = mr; mul_done = md;
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 1, 6'd5, 1, 1);
        tests++; if (obs !== 8'h00) begin fails++; $display("FAIL reset_outputs: got %h expected %h", obs, 8'h00); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== DR) begin fails++; $display("FAIL reset_idle: got %h expected %h", obs, DR); end
        tests++; if (upc !== 6'd0) begin fails++; $display("FAIL reset_upc: got %0d expected 0", upc); end
    endtask

    task automatic test_alu;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6'd1, 0, 0);
        tests++; if (obs !== DR) begin fails++; $display("FAIL alu_accept: got %h expected %h", obs, DR); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== IS) begin fails++; $display("FAIL alu_issue: got %h expected %h", obs, IS); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== RT) begin fails++; $display("FAIL alu_retire: got %h expected %h", obs, RT); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== DR) begin fails++; $display("FAIL alu_ready: got %h expected %h", obs, DR); end
        tests++; if (upc !== 6'd1) begin fails++; $display("FAIL alu_upc: got %0d expected 1", upc); end
    endtask

    task automatic test_mem;
        int reqs = 0, rets = 0, tos = 0;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6'd11, 0, 0);
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== IS) begin fails++; $display("FAIL mem_issue: got %h expected %h", obs, IS); end
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0, 0, k == 5, 0);
            reqs += int'(mem_req); rets += int'(retire); tos += int'(timeout);
        end
        tests++; if (reqs != 6) begin fails++; $display("FAIL mem_req_cycles: got %0d expected 6", reqs); end
        tests++; if (rets != 1) begin fails++; $display("FAIL mem_retires: got %0d expected 1", rets); end
        tests++; if (tos != 0) begin fails++; $display("FAIL mem_timeouts: got %0d expected 0", tos); end
    endtask

    task automatic test_timeout;
        for (int rep = 0; rep < 2; rep++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 1, 6'd12, 0, 0);
            cyc(0, 0, 0, 0, 0);
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0, 0, 0, 0);
                tests++; if (obs4 !== MQ) begin fails++; $display("FAIL to_wait%0d: got %h expected %h", rep, obs4, MQ); end
            end
            cyc(0, 0, 0, rep == 1, 0);
            tests++; if (obs4 !== (rep == 1 ? MQ : MQ | TO)) begin fails++; $display("FAIL to_fourth%0d: got %h expected %h", rep, obs4, rep == 1 ? MQ : MQ | TO); end
            cyc(0, 0, 0, 0, 0);
            tests++; if (obs4 !== (rep == 1 ? RT : DR)) begin fails++; $display("FAIL to_after%0d: got %h expected %h", rep, obs4, rep == 1 ? RT : DR); end
        end
    endtask

    task automatic test_mul;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6'd27, 0, 0);
        cyc(0, 0, 0, 0, 1);
`ifdef USEQ_MUL_EN
        tests++; if (obs !== (IS | MS)) begin fails++; $display("FAIL mul_start: got %h expected %h", obs, IS | MS); end
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 0);
            tests++; if (obs !== 8'h00) begin fails++; $display("FAIL mul_wait: got %h expected %h", obs, 8'h00); end
        end
        cyc(0, 0, 0, 0, 1);
        tests++; if (obs !== 8'h00) begin fails++; $display("FAIL mul_done: got %h expected %h", obs, 8'h00); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== RT) begin fails++; $display("FAIL mul_retire: got %h expected %h", obs, RT); end
`else
        tests++; if (obs !== (IS | IL)) begin fails++; $display("FAIL mul_illegal: got %h expected %h", obs, IS | IL); end
        cyc(0, 0, 0, 0, 1);
        tests++; if (obs !== DR) begin fails++; $display("FAIL mul_idle: got %h expected %h", obs, DR); end
`endif
    endtask

    task automatic test_illegal_mret;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6'd63, 0, 0);
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== (IS | IL)) begin fails++; $display("FAIL ill_pulse: got %h expected %h", obs, IS | IL); end
        cyc(0, 1, 6'd36, 0, 0);
        tests++; if (obs !== DR) begin fails++; $display("FAIL ill_idle: got %h expected %h", obs, DR); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== IS) begin fails++; $display("FAIL mret_issue: got %h expected %h", obs, IS); end
        cyc(0, 0, 0, 0, 0);
        tests++; if (obs !== (RT | TR)) begin fails++; $display("FAIL mret_retire: got %h expected %h", obs, RT | TR); end
    endtask

    task automatic test_reset_mid;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 6'd11, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 6'd9, 1, 0);
        tests++; if (obs !== 8'h00) begin fails++; $display("FAIL rmid_during: got %h expected %h", obs, 8'h00); end
        cyc(0, 0, 0, 1, 0);
        tests++; if (obs !== DR) begin fails++; $display("FAIL rmid_idle: got %h expected %h", obs, DR); end
        tests++; if (upc !== 6'd0) begin fails++; $display("FAIL rmid_upc: got %0d expected 0", upc); end
    endtask

    // Reference: each instruction expands to accept, issue, optional wait, retire per its address class.
    task automatic test_random;
        logic [5:0] a;
        bit mem, mul, bad;
        int w;
        cyc(1, 0, 0, 0, 0);
        for (int t = 0; t < 60; t++) begin
            case ($urandom % 7)
                0: a = ($urandom % 2) ? 6'd11 : 6'd12;
                1: a = 6'(27 + $urandom % 3);
                2: a = 6'd63;
                3: a = 6'(37 + $urandom % 26);
                4: a = 6'd36;
                5: a = 6'd0;
                default: a = 6'($urandom % 37);
            endcase
            mem = a == 6'd11 || a == 6'd12;
            mul = MUL_EN && a >= 6'd27 && a <= 6'd29;
            bad = a > 6'd36 || (!MUL_EN && a >= 6'd27 && a <= 6'd29);
            repeat ($urandom % 3) begin
                cyc(0, 0, 6'($urandom), 1'($urandom), 1'($urandom));
                tests++; if (obs !== DR) begin fails++; $display("FAIL rnd_gap t%0d: got %h expected %h", t, obs, DR); end
            end
            cyc(0, 1, a, 0, 0);
            tests++; if (obs !== DR) begin fails++; $display("FAIL rnd_accept t%0d: got %h expected %h", t, obs, DR); end
            cyc(0, 1, 6'($urandom), 0, 0);
            tests++; if (obs !== (IS | (bad ? IL : 8'h00) | (mul ? MS : 8'h00))) begin
                fails++; $display("FAIL rnd_issue t%0d a%0d: got %h expected %h", t, a, obs, IS | (bad ? IL : 8'h00) | (mul ? MS : 8'h00));
            end
            tests++; if (upc !== a) begin fails++; $display("FAIL rnd_upc t%0d: got %0d expected %0d", t, upc, a); end
            if (!bad) begin
                if (mem || mul) begin
                    w = $urandom % 6;
                    for (int k = 0; k <= w; k++) begin
                        cyc(0, 1'($urandom), 6'($urandom), mem && k == w, mul && k == w);
                        tests++; if (obs !== (mem ? MQ : 8'h00)) begin fails++; $display("FAIL rnd_wait t%0d: got %h expected %h", t, obs, mem ? MQ : 8'h00); end
                    end
                end
                cyc(0, 0, 0, 0, 0);
                tests++; if (obs !== (RT | (a == 6'd36 ? TR : 8'h00))) begin
                    fails++; $display("FAIL rnd_retire t%0d a%0d: got %h expected %h", t, a, obs, RT | (a == 6'd36 ? TR : 8'h00));
                end
                tests++; if (upc !== a) begin fails++; $display("FAIL rnd_upc_hold t%0d: got %0d expected %0d", t, upc, a); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mem;
        test_timeout;
        test_mul;
        test_illegal_mret;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum cycles to wait for mem_ready before aborting (legal range 1..255).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 dec_valid  in  1  decoder presents a mapped microcode address.
REQ-005 mapped_address  in  6  microcode entry address from the address mapper (0..36 legal, 63 illegal).
REQ-006 dec_ready  out  1  sequencer accepts an address this cycle.
REQ-007 mem_ready  in  1  memory completes the outstanding load/store.
REQ-008 mul_done  in  1  multiplier result valid.
REQ-009 upc  out  6  current micro-PC, i.e. the captured entry address.
REQ-010 issue  out  1  one-cycle pulse: upc is valid for execution.
REQ-011 mem_req  out  1  level request to memory while waiting.
REQ-012 mul_start  out  1  one-cycle pulse starting the multiplier.
REQ-013 retire  out  1  one-cycle pulse: instruction completed.
REQ-014 illegal  out  1  one-cycle pulse: address 63, or an unsupported address, was dispatched.
REQ-015 trap_return  out  1  one-cycle pulse coincident with retire for address 36 (MRET).
REQ-016 timeout  out  1  one-cycle pulse: memory wait aborted.

Function
REQ-017 The FSM SHALL have the states IDLE, DISPATCH, WAIT_MEM, WAIT_MUL and RETIRE.
REQ-018 In IDLE, dec_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-019 In IDLE with dec_valid=1, the block SHALL capture mapped_address into upc and go to DISPATCH.
REQ-020 In DISPATCH, issue SHALL be 1 for exactly one cycle.
REQ-021 DISPATCH SHALL route as follows:
- addresses 11 and 12 go to WAIT_MEM;
- addresses 27..29 go to WAIT_MUL and pulse mul_start in the same cycle;
- address 63 pulses illegal and goes to IDLE;
- addresses 37..62 pulse illegal and go to IDLE;
- all other addresses go to RETIRE.
REQ-022 In WAIT_MEM, mem_req SHALL be 1.
REQ-023 In WAIT_MEM, a wait counter SHALL clear on entry and increment each cycle mem_ready=0.
REQ-024 In WAIT_MEM, mem_ready=1 SHALL go to RETIRE.
REQ-025 In WAIT_MEM, when the counter equals MEM_TIMEOUT-1 with mem_ready=0, the block SHALL pulse timeout, drop mem_req and go to IDLE without retire.
REQ-026 If mem_ready and the timeout condition coincide, mem_ready SHALL win: go to RETIRE, no timeout pulse.
REQ-027 WAIT_MUL SHALL hold until mul_done=1, then go to RETIRE; it has no timeout.
REQ-028 RETIRE SHALL pulse retire for one cycle (plus trap_return when upc=36) and go to IDLE.
REQ-029 Latency from dec_valid acceptance at cycle N:
- ALU-class: issue at N+1, retire at N+2, dec_ready again at N+3;
- memory with mem_ready at the first WAIT_MEM cycle: retire at N+3.
REQ-030 upc SHALL hold its value from capture until the next capture; dec_valid outside IDLE SHALL be ignored.
REQ-031 Address 0 (NOP entry) SHALL retire like ALU-class.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL enter IDLE in any state, including mid-wait.
REQ-033 That reset SHALL force upc=0 and the wait counter to 0.
REQ-034 That reset SHALL drive every pulse output and mem_req to 0.
REQ-035 While reset is high, dec_ready SHALL be 0.
REQ-036 Reset SHALL have priority over every input in the same cycle.

Configuration
REQ-037 With macro USEQ_MUL_EN defined, addresses 27..29 SHALL follow the WAIT_MUL path.
REQ-038 With USEQ_MUL_EN undefined, addresses 27..29 SHALL pulse illegal and return to IDLE, mul_start SHALL be tied 0, mul_done SHALL be ignored, and WAIT_MUL logic SHALL be absent.

Structure
REQ-039 A shared package useq_pkg SHALL hold:
- the state enumeration;
- the 6-bit address constants (ADDR_LOAD=11, ADDR_STORE=12, ADDR_MUL_LO=27, ADDR_MUL_HI=29, ADDR_MRET=36, ADDR_ILLEGAL=63);
- the width constant UPC_W=6.
REQ-040 The memory wait counter and its compare SHALL be a sub-module useq_wait_timer (inputs clear/enable, output expired).

Verification
REQ-041 Bench: reset, dec_valid with addr 1 -> issue at cycle 1, retire at cycle 2, dec_ready=1 at cycle 3, upc=1.
REQ-042 Bench: addr 11, mem_ready held 0 for 5 cycles then 1 -> mem_req high 6 cycles, single retire, no timeout.
REQ-043 Bench: MEM_TIMEOUT=4, addr 12, mem_ready=0 -> timeout pulse on the 4th WAIT_MEM cycle, no retire, IDLE next; repeat with mem_ready=1 on that cycle -> retire, no timeout.
REQ-044 Bench: addr 27 with USEQ_MUL_EN -> mul_start pulse, retire one cycle after mul_done; without the macro -> illegal pulse, no mul_start.
REQ-045 Bench: addr 63 -> illegal pulse, no retire; addr 36 -> retire and trap_return in the same cycle.
REQ-046 Bench: reset asserted during WAIT_MEM -> next cycle IDLE, upc=0, mem_req=0, no retire or timeout pulse.
